// File: rtl/pulse_stretch_mc.sv
// Multi-channel edge-triggered pulse stretcher with optional retrigger.
// Define PS_HOLDOFF_EN to add a post-pulse holdoff window per channel.
module pulse_stretch_mc #(
  parameter int unsigned CH      = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    in_pulse,
  input  logic [CNT_W-1:0] len,
  input  logic             retrig,
  output logic [CH-1:0]    out_pulse,
  output logic             busy
);

  if (CH < 1 || CH > 32 || HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_param
    $error("pulse_stretch_mc: CH must be 1..32 and HOLDOFF 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HOLDOFF
  } state_t;

  state_t           state    [CH];
  state_t           state_nx [CH];
  logic [CNT_W-1:0] cnt      [CH];
  logic [CNT_W-1:0] cnt_nx   [CH];
  logic [CH-1:0]    prev;
  logic [CH-1:0]    trig;
  logic [CNT_W-1:0] len_m1;

`ifdef PS_HOLDOFF_EN
  logic [7:0]       hcnt     [CH];
  logic [7:0]       hcnt_nx  [CH];
`endif

  assign trig = in_pulse & ~prev;

  // len==0 behaves as len==1, so both reload the counter with zero.
  assign len_m1 = (len == '0) ? '0 : len - CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    prev <= in_pulse;
    for (int unsigned i = 0; i < CH; i++) begin
      if (rst) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
`ifdef PS_HOLDOFF_EN
        hcnt[i]  <= '0;
`endif
      end else begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
`ifdef PS_HOLDOFF_EN
        hcnt[i]  <= hcnt_nx[i];
`endif
      end
    end
  end

  // Next-state logic
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
`ifdef PS_HOLDOFF_EN
      hcnt_nx[i]  = hcnt[i];
`endif
      case (state[i])
        S_IDLE: begin
          if (trig[i]) begin
            state_nx[i] = S_ACTIVE;
            cnt_nx[i]   = len_m1;
          end
        end
        S_ACTIVE: begin
          // A retrigger wins over expiry, so the output never gaps.
          if (trig[i] && retrig) begin
            cnt_nx[i] = len_m1;
          end else if (cnt[i] == '0) begin
`ifdef PS_HOLDOFF_EN
            state_nx[i] = S_HOLDOFF;
            hcnt_nx[i]  = 8'(HOLDOFF - 1);
`else
            state_nx[i] = S_IDLE;
`endif
          end else begin
            cnt_nx[i] = cnt[i] - CNT_W'(1);
          end
        end
`ifdef PS_HOLDOFF_EN
        S_HOLDOFF: begin
          if (hcnt[i] == '0) begin
            state_nx[i] = S_IDLE;
          end else begin
            hcnt_nx[i] = hcnt[i] - 8'd1;
          end
        end
`endif
        default: begin
          state_nx[i] = S_IDLE;
          cnt_nx[i]   = '0;
        end
      endcase
    end
  end

  // Output decode straight from the state flops
  always_comb begin
    out_pulse = '0;
    busy      = 1'b0;
    for (int unsigned i = 0; i < CH; i++) begin
      out_pulse[i] = (state[i] == S_ACTIVE);
      if (state[i] != S_IDLE) begin
        busy = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Randomized and directed bench for pulse_stretch_mc against a cycle-count reference model.
module tb_pulse_stretch_mc;
  localparam int CH      = 4;
  localparam int CNT_W   = 8;
  localparam int HOLDOFF = 2;
`ifdef PS_HOLDOFF_EN
  localparam int HOLD_CYC = HOLDOFF;
`else
  localparam int HOLD_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    in_pulse;
  logic [CNT_W-1:0] len;
  logic             retrig;
  logic [CH-1:0]    out_pulse;
  logic             busy;

  always #5 clk = ~clk;

  pulse_stretch_mc #(.CH(CH), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .in_pulse(in_pulse), .len(len),
    .retrig(retrig), .out_pulse(out_pulse), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: remaining high cycles and remaining holdoff cycles per channel.
  int rem  [CH];
  int hold [CH];
  bit mprev[CH];
  int hcnt [CH];

  always @(posedge clk) begin
    int L;
    bit t;
    L = (len == 0) ? 1 : int'(len);
    for (int i = 0; i < CH; i++) begin
      t = in_pulse[i] && !mprev[i];
      if (rst) begin
        rem[i]  = 0;
        hold[i] = 0;
      end else if (rem[i] > 0) begin
        if (t && retrig) rem[i] = L;
        else begin
          rem[i]--;
          if (rem[i] == 0) hold[i] = HOLD_CYC;
        end
      end else if (hold[i] > 0) begin
        hold[i]--;
      end else if (t) begin
        rem[i] = L;
      end
      mprev[i] = in_pulse[i];
    end
  end

  task automatic compare();
    logic [CH-1:0] eo;
    logic          eb;
    eo = '0;
    eb = 1'b0;
    for (int i = 0; i < CH; i++) begin
      eo[i] = (rem[i] > 0);
      if (rem[i] > 0 || hold[i] > 0) eb = 1'b1;
    end
    check("out_pulse", 32'(out_pulse), 32'(eo));
    check("busy", 32'(busy), 32'(eb));
    for (int i = 0; i < CH; i++) if (out_pulse[i] === 1'b1) hcnt[i]++;
  endtask

  task automatic cyc(input logic [CH-1:0] ip, input logic [CNT_W-1:0] l,
                     input logic r, input logic rs = 1'b0);
    @(negedge clk);
    compare();
    in_pulse = ip;
    len      = l;
    retrig   = r;
    rst      = rs;
  endtask

  task automatic idle(input int n, input logic [CNT_W-1:0] l = 8'd5, input logic r = 1'b0);
    for (int k = 0; k < n; k++) cyc('0, l, r);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < CH; i++) hcnt[i] = 0;
  endtask

  initial begin
    rst = 1'b1; in_pulse = '0; len = 8'd5; retrig = 1'b0;
    for (int i = 0; i < CH; i++) begin rem[i] = 0; hold[i] = 0; mprev[i] = 0; hcnt[i] = 0; end

    // Inputs high through reset must not trigger
    for (int k = 0; k < 3; k++) cyc(4'hF, 8'd5, 1'b0, 1'b1);
    clear_counts();
    for (int k = 0; k < 4; k++) cyc(4'hF, 8'd5, 1'b0);
    idle(3);
    check("rst_release", 32'(hcnt[0] + hcnt[1] + hcnt[2] + hcnt[3]), 32'd0);

    clear_counts();
    cyc(4'h1, 8'd5, 1'b0); idle(10);
    check("len5_ch0", 32'(hcnt[0]), 32'd5);
    check("len5_others", 32'(hcnt[1] + hcnt[2] + hcnt[3]), 32'd0);

    clear_counts();
    for (int k = 0; k < 3; k++) cyc(4'h2, 8'd5, 1'b0);
    idle(10);
    check("held_input", 32'(hcnt[1]), 32'd5);
    clear_counts();
    cyc(4'h2, 8'd0, 1'b0); idle(6);
    check("len0", 32'(hcnt[1]), 32'd1);

    clear_counts();
    cyc(4'h4, 8'd5, 1'b1); cyc(4'h0, 8'd5, 1'b1); cyc(4'h4, 8'd5, 1'b1); idle(12, 8'd5, 1'b1);
    check("retrig_on", 32'(hcnt[2]), 32'd7);
    clear_counts();
    cyc(4'h4, 8'd5, 1'b0); cyc(4'h0, 8'd5, 1'b0); cyc(4'h4, 8'd5, 1'b0); idle(12);
    check("retrig_off", 32'(hcnt[2]), 32'd5);

    clear_counts();
    cyc(4'h9, 8'd3, 1'b0); idle(8, 8'd9);
    check("simul_ch0", 32'(hcnt[0]), 32'd3);
    check("simul_ch3", 32'(hcnt[3]), 32'd3);

    clear_counts();
    cyc(4'h1, 8'd5, 1'b0); cyc(4'h0, 8'd5, 1'b0); cyc(4'h0, 8'd5, 1'b0, 1'b1); idle(8);
    check("rst_abort", 32'(hcnt[0]), 32'd2);

    // Edge one cycle after the pulse falls: blocked only with holdoff
    clear_counts();
    cyc(4'h1, 8'd2, 1'b0); cyc(4'h0, 8'd2, 1'b0); cyc(4'h0, 8'd2, 1'b0);
    cyc(4'h1, 8'd2, 1'b0); idle(8, 8'd2);
    check("edge_plus1", 32'(hcnt[0]), 32'(HOLD_CYC > 0 ? 2 : 4));
    clear_counts();
    cyc(4'h1, 8'd2, 1'b0);
    for (int k = 0; k < 4; k++) cyc(4'h0, 8'd2, 1'b0);
    cyc(4'h1, 8'd2, 1'b0); idle(8, 8'd2);
    check("edge_plus3", 32'(hcnt[0]), 32'd4);

    clear_counts();
    cyc(4'h8, 8'd255, 1'b0); idle(262, 8'd255);
    check("len_max", 32'(hcnt[3]), 32'd255);

    for (int k = 0; k < 600; k++) begin
      logic [CH-1:0] ip;
      for (int i = 0; i < CH; i++) ip[i] = ($urandom_range(0, 2) == 0);
      cyc(ip, 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 79) == 0));
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
